aim65_ps2_rx: RTL and testbench

AIM65_PS2_RX -- requirements
Module: aim65_ps2_rx

---
 rtl/aim65_ps2_rx.sv | 199 +++++++++++++++++++
 tb/tb_aim65_ps2_rx.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/aim65_ps2_rx.sv
// aim65_ps2_rx: PS/2 keyboard receiver. It decodes scancode frames into key events.
//
// The raw PS/2 clock and data lines are synchronized first. The clock is then
// de-glitched by a level filter. Data is sampled on each filtered falling edge.
// Each 11-bit frame is: start, 8 data bits (LSB first), odd parity, stop.
// Good bytes go through a small decoder:
//   - E0 sets the extended-key flag.
//   - F0 sets the break flag.
//   - E1 starts a Pause sequence, whose following 7 bytes are skipped.
//   - Keyboard status bytes (00, AA, EE, FA, FE, FF) are dropped when no
//     prefix flag is set.
//   - Every other byte is reported on ps2_key.
//
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   ps2_clk_in   raw keyboard clock (asynchronous)
//   ps2_data_in  raw keyboard data (asynchronous)
//   ps2_key      [10] event toggle, [9] make(1)/break(0), [8] E0-extended,
//                [7:0] scancode
//   rx_error     one-cycle pulse on a parity, stop-bit or timeout failure
module aim65_ps2_rx #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ps2_clk_in,
  input  logic        ps2_data_in,
  output logic [10:0] ps2_key,
  output logic        rx_error
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t          state, state_nxt;
  logic [1:0]      clk_sync, data_sync;
  logic            data_s;
  logic [FW-1:0]   filt_cnt;
  logic            filt_clk, filt_prev;
  logic            bit_edge, timeout;
  logic            shift_en, par_en, stop_en;
  logic [TW-1:0]   to_cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shreg;
  logic            par_bit;
  logic            frame_bad;
  logic            byte_vld;
  logic [2:0]      skip_cnt;
  logic            ext, brk;
  logic            is_filler;

  assign data_s = data_sync[1];

  // Two-flop synchronizers. They idle high, like the PS/2 bus does.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk_in};
      data_sync <= {data_sync[0], ps2_data_in};
    end
  end

  // Level filter: the filtered clock flips only after FILTER_LEN
  // back-to-back samples at the opposite level.
  always_ff @(posedge clk) begin
    if (reset) begin
      filt_cnt  <= '0;
      filt_clk  <= 1'b1;
      filt_prev <= 1'b1;
    end else begin
      filt_prev <= filt_clk;
      if (clk_sync[1] == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FILT_MAX) begin
        filt_clk <= clk_sync[1];
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + FW'(1);
      end
    end
  end

  assign bit_edge = filt_prev & ~filt_clk;
  assign timeout  = (state != IDLE) && (to_cnt == TO_MAX);

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM next state. A timeout overrides a bit edge in the same cycle.
  always_comb begin
    state_nxt = state;
    if (timeout) begin
      state_nxt = IDLE;
    end else if (bit_edge) begin
      case (state)
        IDLE:    if (!data_s) state_nxt = DATA;
        DATA:    if (bit_cnt == 3'd7) state_nxt = PARITY;
        PARITY:  state_nxt = STOP;
        STOP:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    shift_en = 1'b0;
    par_en   = 1'b0;
    stop_en  = 1'b0;
    if (bit_edge && !timeout) begin
      case (state)
        DATA:    shift_en = 1'b1;
        PARITY:  par_en   = 1'b1;
        STOP:    stop_en  = 1'b1;
        default: ;
      endcase
    end
  end

  // A frame is bad if the stop bit is 0, or if data plus parity has an even
  // number of ones.
  assign frame_bad = !data_s || !(^{shreg, par_bit});

  always_comb begin
    is_filler = 1'b0;
    case (shreg)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: is_filler = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt   <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      byte_vld <= 1'b0;
      skip_cnt <= '0;
      ext      <= 1'b0;
      brk      <= 1'b0;
      ps2_key  <= '0;
      rx_error <= 1'b0;
    end else begin
      rx_error <= 1'b0;
      byte_vld <= 1'b0;

      if (state == IDLE || bit_edge || timeout) to_cnt <= '0;
      else                                      to_cnt <= to_cnt + TW'(1);

      if (shift_en) begin
        shreg   <= {data_s, shreg[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end else if (state == IDLE) begin
        bit_cnt <= '0;
      end

      if (par_en) par_bit <= data_s;
      if (stop_en && !frame_bad) byte_vld <= 1'b1;

      // The decode step reads shreg directly. The filter guarantees that no
      // new bit edge can arrive one cycle after a stop edge.
      if (byte_vld) begin
        if (skip_cnt != 3'd0) begin
          skip_cnt <= skip_cnt - 3'd1;
        end else if (shreg == 8'hE1) begin
          skip_cnt <= 3'd7;
        end else if (shreg == 8'hE0) begin
          ext <= 1'b1;
        end else if (shreg == 8'hF0) begin
          brk <= 1'b1;
        end else if (!(ext || brk) && is_filler) begin
          // status byte from the keyboard, not a key
        end else begin
          ps2_key <= {~ps2_key[10], ~brk, ext, shreg};
          ext     <= 1'b0;
          brk     <= 1'b0;
        end
      end

      if (timeout || (stop_en && frame_bad)) begin
        rx_error <= 1'b1;
        ext      <= 1'b0;
        brk      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_aim65_ps2_rx.sv
// Testbench for aim65_ps2_rx.
// A table of frames is applied, each row with a hand-computed expected key
// and a running rx_error pulse count. Hand-written sequences then cover:
// timeout, clock glitch rejection, and reset in the middle of a frame.
module tb_aim65_ps2_rx;

  localparam int FL   = 8;
  localparam int TO   = 1000;
  localparam int HALF = 20;

  logic        clk = 1'b0;
  logic        reset;
  logic        ps2_clk_in;
  logic        ps2_data_in;
  logic [10:0] ps2_key;
  logic        rx_error;

  int errors = 0;
  int checks = 0;
  int err_seen = 0;

  aim65_ps2_rx #(.FILTER_LEN(FL), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_key(ps2_key), .rx_error(rx_error)
  );

  always #5 clk = ~clk;

  // Counts high cycles, so a pulse longer than one cycle shows up as extra errors.
  always @(negedge clk) if (rx_error) err_seen++;

  typedef struct {
    logic [7:0]  b;
    logic        bad_par;
    logic        stop;
    logic [10:0] key;
    int          errs;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [7:0] b, input logic bp, input logic st,
                     input logic [10:0] k, input int e);
    vec_t v;
    v.b = b; v.bad_par = bp; v.stop = st; v.key = k; v.errs = e;
    vecs.push_back(v);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] frame(input logic [7:0] b, input logic bp, input logic st);
    return {st, (~^b) ^ bp, b, 1'b0};
  endfunction

  // Sends the first nbits of a frame, starting with the start bit.
  // With glitch set, a short low pulse is added in each high phase.
  task automatic send_bits(input logic [10:0] bits, input int nbits, input bit glitch);
    for (int i = 0; i < nbits; i++) begin
      ps2_data_in = bits[i];
      tick(HALF);
      ps2_clk_in = 1'b0;
      tick(HALF);
      ps2_clk_in = 1'b1;
      if (glitch) begin
        tick(HALF);
        ps2_clk_in = 1'b0;
        tick(FL - 2);
        ps2_clk_in = 1'b1;
      end
      tick(HALF);
    end
  endtask

  initial begin
    reset = 1'b1;
    ps2_clk_in = 1'b1;
    ps2_data_in = 1'b1;

    add(8'h1C, 0, 1, 11'h61C, 0);
    add(8'hF0, 0, 1, 11'h61C, 0);
    add(8'h1C, 0, 1, 11'h01C, 0);
    add(8'hE0, 0, 1, 11'h01C, 0);
    add(8'h75, 0, 1, 11'h775, 0);
    add(8'h1C, 1, 1, 11'h775, 1);   // parity error
    add(8'h1C, 0, 1, 11'h21C, 1);
    add(8'hAA, 0, 1, 11'h21C, 1);   // status byte dropped
    add(8'hE0, 0, 1, 11'h21C, 1);
    add(8'hF0, 0, 1, 11'h21C, 1);
    add(8'h7C, 0, 1, 11'h57C, 1);
    add(8'hF0, 0, 1, 11'h57C, 1);
    add(8'hE0, 0, 1, 11'h57C, 1);
    add(8'h70, 0, 1, 11'h170, 1);
    add(8'h15, 0, 0, 11'h170, 2);   // stop bit 0
    add(8'h15, 0, 1, 11'h615, 2);
    add(8'hE0, 0, 1, 11'h615, 2);
    add(8'h11, 1, 1, 11'h615, 3);   // error clears pending E0
    add(8'h11, 0, 1, 11'h211, 3);
    add(8'hE1, 0, 1, 11'h211, 3);   // Pause: skip next 7
    add(8'h14, 0, 1, 11'h211, 3);
    add(8'h77, 0, 1, 11'h211, 3);
    add(8'hE1, 0, 1, 11'h211, 3);
    add(8'hF0, 0, 1, 11'h211, 3);
    add(8'h14, 0, 1, 11'h211, 3);
    add(8'hF0, 0, 1, 11'h211, 3);
    add(8'h77, 0, 1, 11'h211, 3);
    add(8'h16, 0, 1, 11'h616, 3);
    add(8'hF0, 0, 1, 11'h616, 3);
    add(8'hF0, 0, 1, 11'h616, 3);   // repeated prefix
    add(8'h16, 0, 1, 11'h016, 3);
    add(8'hFA, 0, 1, 11'h016, 3);
    add(8'hF0, 0, 1, 11'h016, 3);
    add(8'h00, 0, 1, 11'h400, 3);   // 00 reported when prefixed

    tick(5);
    check("reset key", ps2_key, 11'h000);
    check("reset err", rx_error, 1'b0);
    reset = 1'b0;
    tick(5);

    for (int i = 0; i < vecs.size(); i++) begin
      send_bits(frame(vecs[i].b, vecs[i].bad_par, vecs[i].stop), 11, 1'b0);
      tick(20);
      check($sformatf("vec%0d key", i), ps2_key, vecs[i].key);
      check($sformatf("vec%0d errs", i), err_seen, vecs[i].errs);
    end

    // timeout after 4 data bits
    send_bits(frame(8'h29, 0, 1), 5, 1'b0);
    tick(TO + 10);
    check("timeout errs", err_seen, 4);
    check("timeout key", ps2_key, 11'h400);
    send_bits(frame(8'h29, 0, 1), 11, 1'b0);
    tick(20);
    check("post-timeout key", ps2_key, 11'h229);
    check("post-timeout errs", err_seen, 4);

    // short clock glitches must not add bits
    send_bits(frame(8'h29, 0, 1), 11, 1'b1);
    tick(20);
    check("glitch key", ps2_key, 11'h629);
    check("glitch errs", err_seen, 4);

    // reset in the middle of a frame
    send_bits(frame(8'h1C, 0, 1), 6, 1'b0);
    reset = 1'b1;
    tick(3);
    check("midreset key", ps2_key, 11'h000);
    reset = 1'b0;
    ps2_data_in = 1'b1;
    tick(TO + 10);
    check("midreset errs", err_seen, 4);
    send_bits(frame(8'h1C, 0, 1), 11, 1'b0);
    tick(20);
    check("after reset key", ps2_key, 11'h61C);
    check("after reset errs", err_seen, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
